// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store controller
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MEM_AW_DEF = 12;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte lanes, store replication, load extension and legality checks
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        f3_bad_o,
    output logic        misalign_o
);

    logic [31:0] shifted;

    // Store lane enables and data replicated across every lane the access could hit
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                be_o    = we_i ? (4'b0001 << addr_lo_i) : 4'b0000;
                wdata_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                be_o    = we_i ? (4'b0011 << addr_lo_i) : 4'b0000;
                wdata_o = {2{wdata_i[15:0]}};
            end
            F3_W: begin
                be_o    = we_i ? 4'b1111 : 4'b0000;
                wdata_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Load data: bring the addressed byte/half down to bit 0, then extend
    always_comb begin
        shifted = mem_rdata_i >> {addr_lo_i, 3'b000};
        rdata_o = shifted;
        case (funct3_i)
            F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_o = {24'h0, shifted[7:0]};
            F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata_o = {16'h0, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

    // Width code legality (stores have no unsigned forms) and natural alignment
    always_comb begin
        if (we_i) begin
            f3_bad_o = !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W);
        end else begin
            f3_bad_o = !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W ||
                         funct3_i == F3_BU || funct3_i == F3_HU);
        end
        misalign_o = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store controller for a synchronous word RAM
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_adr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [MEM_AW+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              accept;

    logic              sel_req;
    logic              al_we;
    logic [2:0]        al_f3;
    logic [1:0]        al_addr_lo;
    logic [31:0]       al_wdata;
    logic [3:0]        al_be;
    logic [31:0]       al_wrep;
    logic [31:0]       al_rdata;
    logic              al_f3_bad;
    logic              al_misalign;
    logic              range_bad;
    logic              req_bad;

    // In IDLE the aligner judges the incoming request; afterwards it works on the held fields
    assign sel_req    = (state_q == ST_IDLE);
    assign al_we      = sel_req ? req_we             : we_q;
    assign al_f3      = sel_req ? req_funct3         : f3_q;
    assign al_addr_lo = sel_req ? req_addr[1:0]      : addr_q[1:0];
    assign al_wdata   = sel_req ? req_wdata          : wdata_q;

    lsu_align u_align (
        .we_i        (al_we),
        .funct3_i    (al_f3),
        .addr_lo_i   (al_addr_lo),
        .wdata_i     (al_wdata),
        .mem_rdata_i (mem_rdata),
        .be_o        (al_be),
        .wdata_o     (al_wrep),
        .rdata_o     (al_rdata),
        .f3_bad_o    (al_f3_bad),
        .misalign_o  (al_misalign)
    );

    assign range_bad = |req_addr[31:MEM_AW+2];
    assign req_bad   = al_f3_bad || al_misalign || range_bad;

    // State register; reset abandons whatever access or response is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Request fields are captured once, on the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[MEM_AW+1:0];
            wdata_q <= req_wdata;
        end
    end

    // Next-state and response contents
    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        accept      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept      = 1'b1;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = req_bad;
                    state_d     = req_bad ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = we_q ? ST_RESP : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                rsp_rdata_d = al_rdata;
                rsp_err_d   = 1'b0;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory port is quiet outside ACCESS so reset or errors can never touch the RAM
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_adr   = '0;
        mem_wdata = 32'h0;
        if (state_q == ST_ACCESS) begin
            mem_en    = 1'b1;
            mem_we    = al_be;
            mem_adr   = addr_q[MEM_AW+1:2];
            mem_wdata = al_wrep;
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl against a synchronous RAM model
module tb_lsu_ctrl;

    localparam int AW = 12;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_adr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [32:0]   sb_q [$];

    int checks = 0;
    int errors = 0;

    lsu_ctrl #(.MEM_AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'hC0DE_0000 | i;
        mem_rdata <= 32'h0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_adr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[mem_adr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got response %h/%0d expected none", rsp_rdata, rsp_err);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                chk("sb_rdata", rsp_rdata, e[32:1]);
                chk("sb_err", {31'h0, rsp_err}, {31'h0, e[0]});
            end
        end
    end

    task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata_exp, input logic err_exp,
                          input logic [3:0] we_exp, input logic [AW-1:0] adr_exp,
                          input logic [31:0] wdata_exp, input int hold);
        int k;
        int lat;
        int en_cnt;
        bit got;
        logic [3:0]    we_seen;
        logic [AW-1:0] adr_seen;
        logic [31:0]   wd_seen;
        we_seen  = 4'h0;
        adr_seen = '0;
        wd_seen  = 32'h0;
        @(negedge clk);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        rsp_ready  = (hold == 0);
        sb_q.push_back({rdata_exp, err_exp});
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_ready"}, {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        en_cnt = 0;
        got = 0;
        lat = -1;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++;
                we_seen  = mem_we;
                adr_seen = mem_adr;
                wd_seen  = mem_wdata;
            end
            if (rsp_valid) begin
                got = 1;
                lat = c - 1;
            end
        end
        chk({name, "_got_rsp"}, {31'h0, got}, 32'h1);
        chk({name, "_latency"}, lat, err_exp ? 0 : (we ? 1 : 2));
        chk({name, "_mem_en_cycles"}, en_cnt, err_exp ? 0 : 1);
        if (!err_exp) begin
            chk({name, "_mem_we"}, {28'h0, we_seen}, {28'h0, we_exp});
            chk({name, "_mem_adr"}, {{(32-AW){1'b0}}, adr_seen}, {{(32-AW){1'b0}}, adr_exp});
            if (we) chk({name, "_mem_wdata"}, wd_seen, wdata_exp);
        end
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                if (i > 0) @(negedge clk);
                chk({name, "_hold_valid"}, {31'h0, rsp_valid}, 32'h1);
                chk({name, "_hold_rdata"}, rsp_rdata, rdata_exp);
                chk({name, "_hold_req_ready"}, {31'h0, req_ready}, 32'h0);
                chk({name, "_hold_mem_en"}, {31'h0, mem_en}, 32'h0);
            end
            @(negedge clk);
            rsp_ready = 1'b1;
            @(negedge clk);
            chk({name, "_idle_after_hs"}, {31'h0, req_ready}, 32'h1);
            chk({name, "_valid_after_hs"}, {31'h0, rsp_valid}, 32'h0);
        end else begin
            @(posedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst_mem_we", {28'h0, mem_we}, 32'h0);
        chk("rst_mem_adr", {{(32-AW){1'b0}}, mem_adr}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_first_ready", {31'h0, req_ready}, 32'h1);

        //      name      we   f3      addr          wdata         rdata_exp     err  we_exp   adr     wdata_exp     hold
        do_req("sw10",   1, 3'b010, 32'h0000_0010, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 12'h004, 32'hDEADBEEF, 0);
        do_req("lw10",   0, 3'b010, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 12'h004, 32'h0,        0);
        do_req("sb13",   1, 3'b000, 32'h0000_0013, 32'h0000_0080, 32'h0,       0, 4'b1000, 12'h004, 32'h80808080, 0);
        do_req("lb13",   0, 3'b000, 32'h0000_0013, 32'h0,        32'hFFFFFF80, 0, 4'b0000, 12'h004, 32'h0,        0);
        do_req("lbu13",  0, 3'b100, 32'h0000_0013, 32'h0,        32'h00000080, 0, 4'b0000, 12'h004, 32'h0,        0);
        do_req("lw10b",  0, 3'b010, 32'h0000_0010, 32'h0,        32'h80ADBEEF, 0, 4'b0000, 12'h004, 32'h0,        0);
        do_req("sh20",   1, 3'b001, 32'h0000_0020, 32'h5555ABCD, 32'h0,        0, 4'b0011, 12'h008, 32'hABCDABCD, 0);
        do_req("lh20",   0, 3'b001, 32'h0000_0020, 32'h0,        32'hFFFFABCD, 0, 4'b0000, 12'h008, 32'h0,        0);
        do_req("lhu20",  0, 3'b101, 32'h0000_0020, 32'h0,        32'h0000ABCD, 0, 4'b0000, 12'h008, 32'h0,        0);
        do_req("lh22",   0, 3'b001, 32'h0000_0022, 32'h0,        32'hFFFFC0DE, 0, 4'b0000, 12'h008, 32'h0,        0);
        do_req("sh26",   1, 3'b001, 32'h0000_0026, 32'h0000_1234, 32'h0,       0, 4'b1100, 12'h009, 32'h12341234, 0);
        do_req("lw24",   0, 3'b010, 32'h0000_0024, 32'h0,        32'h12340009, 0, 4'b0000, 12'h009, 32'h0,        0);
        do_req("lh21",   0, 3'b001, 32'h0000_0021, 32'h0,        32'h0,        1, 4'b0000, 12'h000, 32'h0,        0);
        do_req("lw22",   0, 3'b010, 32'h0000_0022, 32'h0,        32'h0,        1, 4'b0000, 12'h000, 32'h0,        0);
        do_req("ld011",  0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        1, 4'b0000, 12'h000, 32'h0,        0);
        do_req("sw10000",1, 3'b010, 32'h0001_0000, 32'h1111_2222, 32'h0,       1, 4'b0000, 12'h000, 32'h0,        0);
        do_req("sbu",    1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        1, 4'b0000, 12'h000, 32'h0,        0);
        do_req("lw4000", 0, 3'b010, 32'h0000_4000, 32'h0,        32'h0,        1, 4'b0000, 12'h000, 32'h0,        0);
        do_req("lw3ffc", 0, 3'b010, 32'h0000_3FFC, 32'h0,        32'hC0DE0FFF, 0, 4'b0000, 12'hFFF, 32'h0,        5);

        @(negedge clk);
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0040;
        req_wdata  = 32'h1234_5678;
        req_valid  = 1'b1;
        rsp_ready  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("rstacc_mem_en_before", {31'h0, mem_en}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstacc_mem_en", {31'h0, mem_en}, 32'h0);
        chk("rstacc_mem_we", {28'h0, mem_we}, 32'h0);
        chk("rstacc_mem_adr", {{(32-AW){1'b0}}, mem_adr}, 32'h0);
        chk("rstacc_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rstacc_req_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstacc_first_ready", {31'h0, req_ready}, 32'h1);
        do_req("lw40",   0, 3'b010, 32'h0000_0040, 32'h0,        32'hC0DE0010, 0, 4'b0000, 12'h010, 32'h0,        0);

        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
